lsu_mem_bridge: RTL

- Load/store unit directly downstream of the single-cycle datapath. It consumes dAddr, dWdata, the funct3 field and the load/store enables, and returns the extended load data as dRdata.
- Converts byte, halfword and word accesses into word-aligned bus transactions with byte enables, over a req/ack handshake to data memory.
- Drives stall so the CPU top holds the PC and suppresses the register write until the access retires.

---
 rtl/lsu_mem_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the single-cycle datapath and a req/ack data memory bus.
// Byte/half/word accesses become word-aligned bus transactions with byte enables.
// Loads are sign- or zero-extended on the way back. Stall holds the CPU until the
// access retires.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), synchronous active-high reset
//   i_mem_rd_en           current instruction is a load
//   i_mem_wr_en           current instruction is a store (wins over a load)
//   i_funct3              access size/sign (instr[14:12])
//   i_daddr, i_dwdata     byte address and store data
//   o_drdata              extended load data to writeback
//   o_stall               hold PC and block register write while high
//   o_misaligned          one-cycle pulse: illegal or misaligned access rejected
//   o_bus_err             one-cycle pulse: ack timeout
//   o_bus_req/we/addr/be/wdata   bus request side, stable until acked
//   i_bus_ack, i_bus_rdata       bus response side
module lsu_mem_bridge #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_rd_en,
    input  logic        i_mem_wr_en,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dwdata,
    output logic [31:0] o_drdata,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e             r_state, w_state_next;
    logic [31:0]        r_bus_addr, r_bus_wdata, r_cap, r_drdata;
    logic               r_bus_we, r_bus_err;
    logic [3:0]         r_bus_be;
    logic [1:0]         r_off;
    logic [2:0]         r_funct3;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_req, w_illegal, w_misal, w_reject, w_start, w_timeout;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata, w_ext;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;

    // Request decode: legality, alignment, lane enables and replicated store data.
    always_comb begin
        w_req     = i_mem_wr_en | i_mem_rd_en;
        // 011, 11x illegal; 10x (unsigned loads) illegal as stores.
        w_illegal = (i_funct3[1:0] == 2'b11) | (i_funct3[2] & i_funct3[1])
                  | (i_funct3[2] & i_mem_wr_en);
        w_misal   = 1'b0;
        w_be      = 4'b1111;
        w_wdata   = i_dwdata;
        case (i_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_daddr[1:0];
                w_wdata = {4{i_dwdata[7:0]}};
            end
            2'b01: begin
                w_misal = i_daddr[0];
                w_be    = i_daddr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_dwdata[15:0]}};
            end
            default: w_misal = |i_daddr[1:0];
        endcase
        w_reject = w_req & (w_illegal | w_misal);
        w_start  = w_req & ~w_illegal & ~w_misal;
    end

    assign w_timeout = (r_state == StReq) & ~i_bus_ack
                     & (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

    // Load extraction from the captured word using the registered byte offset.
    always_comb begin
        case (r_off)
            2'd0:    w_byte = r_cap[7:0];
            2'd1:    w_byte = r_cap[15:8];
            2'd2:    w_byte = r_cap[23:16];
            default: w_byte = r_cap[31:24];
        endcase
        w_half = r_off[1] ? r_cap[31:16] : r_cap[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = r_cap;
        endcase
    end

    // FSM: state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    // FSM: next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_start) w_state_next = StReq;
            StReq:   if (i_bus_ack || w_timeout) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        o_bus_req    = (r_state == StReq);
        o_stall      = ((r_state == StIdle) & w_start) | (r_state == StReq);
        o_misaligned = (r_state == StIdle) & w_reject;
        case (r_state)
            StIdle:  o_drdata = w_reject ? 32'd0 : r_drdata;
            StDone:  o_drdata = r_bus_we ? r_drdata : w_ext;
            default: o_drdata = r_drdata;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= '0;
            r_bus_err   <= 1'b0;
            r_off       <= '0;
            r_funct3    <= '0;
            r_cap       <= '0;
            r_drdata    <= '0;
            r_cnt       <= '0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_bus_addr  <= {i_daddr[31:2], 2'b00};
                        r_bus_we    <= i_mem_wr_en;
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_off       <= i_daddr[1:0];
                        r_funct3    <= i_funct3;
                        r_cnt       <= '0;
                    end else if (w_reject) begin
                        r_drdata <= '0;
                    end
                end
                StReq: begin
                    if (i_bus_ack) begin
                        if (!r_bus_we) r_cap <= i_bus_rdata;
                        r_cnt <= '0;
                    end else if (w_timeout) begin
                        r_cap     <= '0;
                        r_bus_err <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: if (!r_bus_we) r_drdata <= w_ext;
                default: ;
            endcase
        end
    end

    assign o_bus_addr  = r_bus_addr;
    assign o_bus_we    = r_bus_we;
    assign o_bus_be    = r_bus_be;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_err   = r_bus_err;

endmodule
